issue_hazard_unit: RTL and testbench
====================================

# issue_hazard_unit

Issue-control stage of the dual-issue pipeline. It sits between the ID stage and EX. Each cycle it checks the ID bundle (slot 1, slot 2) for load-use hazards against the instructions currently in EX and for slot-1→slot-2 RAW dependencies. It then issues both slots, splits the bundle over two cycles, or stalls. Its registered EX-side outputs (`ex_rs*`, `ex_rt*`, `ex_rd*`, `ex_regwrite*`) are the `Rs/Rt_EX` and destination fields consumed by the forwarding unit and the EX/MEM register.

## Interface
- `REG_W`, 5, register-index width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `id_valid`  in  1  IF/ID bundle holds valid instructions
- `flush`  in  1  taken branch resolved in EX; kill everything in ID/issue
- `id_rs1`, `id_rt1`, `id_rd1`  in  REG_W each  slot-1 source/dest indices
- `id_regwrite1`, `id_memread1`  in  1 each  slot-1 control
- `id_rs2`, `id_rt2`, `id_rd2`  in  REG_W each  slot-2 source/dest indices
- `id_regwrite2`, `id_memread2`  in  1 each  slot-2 control
- `pc_write`  out  1  combinational; PC may advance
- `if_id_write`  out  1  combinational; IF/ID may load
- `ex_valid1`, `ex_valid2`  out  1 each  registered; EX slot holds a real instruction
- `ex_rs1`, `ex_rt1`, `ex_rd1`, `ex_rs2`, `ex_rt2`, `ex_rd2`  out  REG_W each  registered EX fields
- `ex_regwrite1`, `ex_memread1`, `ex_regwrite2`, `ex_memread2`  out  1 each  registered EX control

## Operation
- **Bubble:** valid=0, regwrite=0, memread=0, rs/rt/rd=0. A bubble never triggers forwarding.
- **lu(x):** load-use hazard on ID instruction x. True if any EX slot k has `ex_valid_k & ex_memread_k & ex_rd_k!=0` and `ex_rd_k` equals `x.rs` or `x.rt`.
- **dep:** intra-bundle dependency. True when `id_regwrite1 & id_rd1!=0` and `id_rd1` equals `id_rs2` or `id_rt2`.
- Register 0 never causes a hazard or dependency. WAW within a bundle is allowed: forwarding gives slot 2 priority.
- States: PAIR and SECOND.
- **PAIR**, first matching rule wins:
  - `flush`: both slots bubble; `pc_write=1`; `if_id_write=1`; stay PAIR.
  - `!id_valid`: both slots bubble; `pc_write=1`; `if_id_write=1`.
  - `lu(inst1)`: both slots bubble; `pc_write=0`; `if_id_write=0`; stay PAIR.
  - `lu(inst2)` or `dep`: issue slot 1 only, slot 2 bubble; `pc_write=0`; `if_id_write=0`; go to SECOND.
  - Otherwise: issue both slots; `pc_write=1`; `if_id_write=1`.
- **SECOND**, where the IF/ID bundle is held and slot 1 was already issued:
  - `flush`: both slots bubble; `pc_write=1`; `if_id_write=1`; go to PAIR.
  - `lu(inst2)`: both slots bubble; `pc_write=0`; `if_id_write=0`; stay SECOND.
  - Otherwise: slot 1 bubble, issue inst2 into slot 2 (it stays in slot 2); `pc_write=1`; `if_id_write=1`; go to PAIR.
- `flush` has priority over every hazard in both states.

## Timing
- Issue latency is one cycle: the decision in cycle n appears on `ex_*` after the rising edge ending cycle n.
- `pc_write` and `if_id_write` are combinational from the state, the ID inputs and the registered `ex_*`. They are forced to 0 while `rst=1`.
- Load-use stall costs exactly one bubble cycle.
- Dependency split costs exactly one extra cycle when no load-use hazard exists.
- Reset, including mid-SECOND: state=PAIR; every `ex_*` output is 0 after the edge; the held bundle is abandoned.

## Structure
- Shared pipeline package holds:
  - state enum (PAIR, SECOND)
  - `REG_ZERO` constant
  - bubble constant for the EX field bundle
- One natural sub-module, `lu_detect`: compares one ID instruction's rs/rt against both EX slots. It is instantiated twice, once for inst1 and once for inst2.

## Test plan
- **Independent pair:** `add $3,$1,$2` + `add $6,$4,$5`, `id_valid=1` → next cycle `ex_valid1=ex_valid2=1`, `ex_rd1=3`, `ex_rd2=6`; `pc_write=1`.
- **Dependency split:** inst1 rd=3 regwrite; inst2 rs=3 → cycle 1: `ex_valid1=1`, `ex_valid2=0`, `pc_write=0`. Cycle 2: `ex_valid1=0`, `ex_valid2=1`, `ex_rs2=3`, `pc_write=1`. State returns to PAIR.
- **Load-use, slot 1:** EX slot 1 is `lw` rd=8; ID inst1 rs=8 → one cycle with both slots bubble and `pc_write=if_id_write=0`, then both issue.
- **Load-use, slot 2 only:** EX `lw` rd=8; ID inst1 independent; inst2 rt=8 → inst1 issues alone; next cycle inst2 issues in slot 2.
- **$0 and flush:** inst1 rd=0 with inst2 rs=0 → no split. Then `flush=1` while in SECOND → both slots bubble, `pc_write=1`, state=PAIR.
- **Reset mid-SECOND:** assert `rst` in SECOND → all `ex_*`=0 after the edge; `pc_write=0` during reset; after release an independent pair issues normally.

Source files
------------

// File: rtl/issue_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : issue_hazard_unit_pkg
// Description : Shared issue-stage types: FSM states, EX slot bundle, constants.
// Revision    : 1.0 - initial release
// ============================================================================
package issue_hazard_unit_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [0:0] {
        ST_PAIR   = 1'b0,
        ST_SECOND = 1'b1
    } issue_state_t;

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memread;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } ex_slot_t;

    localparam ex_slot_t EX_BUBBLE = '0;

endpackage : issue_hazard_unit_pkg
`default_nettype wire

// File: rtl/issue_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_hazard_unit_if
// Description : ID-side bundle, stall controls and registered EX-side fields.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_hazard_unit_if
    import issue_hazard_unit_pkg::*;
();
    logic             id_valid;
    logic             flush;
    logic [REG_W-1:0] id_rs1, id_rt1, id_rd1;
    logic             id_regwrite1, id_memread1;
    logic [REG_W-1:0] id_rs2, id_rt2, id_rd2;
    logic             id_regwrite2, id_memread2;

    logic             pc_write;
    logic             if_id_write;
    logic             ex_valid1, ex_valid2;
    logic [REG_W-1:0] ex_rs1, ex_rt1, ex_rd1;
    logic [REG_W-1:0] ex_rs2, ex_rt2, ex_rd2;
    logic             ex_regwrite1, ex_memread1, ex_regwrite2, ex_memread2;

    modport master (
        output id_valid, flush,
        output id_rs1, id_rt1, id_rd1, id_regwrite1, id_memread1,
        output id_rs2, id_rt2, id_rd2, id_regwrite2, id_memread2,
        input  pc_write, if_id_write, ex_valid1, ex_valid2,
        input  ex_rs1, ex_rt1, ex_rd1, ex_rs2, ex_rt2, ex_rd2,
        input  ex_regwrite1, ex_memread1, ex_regwrite2, ex_memread2
    );

    modport slave (
        input  id_valid, flush,
        input  id_rs1, id_rt1, id_rd1, id_regwrite1, id_memread1,
        input  id_rs2, id_rt2, id_rd2, id_regwrite2, id_memread2,
        output pc_write, if_id_write, ex_valid1, ex_valid2,
        output ex_rs1, ex_rt1, ex_rd1, ex_rs2, ex_rt2, ex_rd2,
        output ex_regwrite1, ex_memread1, ex_regwrite2, ex_memread2
    );

endinterface : issue_hazard_unit_if
`default_nettype wire

// File: rtl/issue_hazard_unit_lu_detect.sv
`default_nettype none
// ============================================================================
// Module      : lu_detect
// Description : Load-use check of one ID instruction's sources against both EX slots.
// Revision    : 1.0 - initial release
// ============================================================================
module lu_detect
    import issue_hazard_unit_pkg::*;
(
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_ex1_valid,
    input  logic             i_ex1_memread,
    input  logic [REG_W-1:0] i_ex1_rd,
    input  logic             i_ex2_valid,
    input  logic             i_ex2_memread,
    input  logic [REG_W-1:0] i_ex2_rd,
    output logic             o_hazard
);

    logic w_hit1;
    logic w_hit2;

    // A load targeting $0 produces nothing to wait for.
    assign w_hit1 = i_ex1_valid && i_ex1_memread && (i_ex1_rd != REG_ZERO) &&
                    ((i_ex1_rd == i_rs) || (i_ex1_rd == i_rt));
    assign w_hit2 = i_ex2_valid && i_ex2_memread && (i_ex2_rd != REG_ZERO) &&
                    ((i_ex2_rd == i_rs) || (i_ex2_rd == i_rt));

    assign o_hazard = w_hit1 || w_hit2;

endmodule : lu_detect
`default_nettype wire

// File: rtl/issue_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : issue_hazard_unit
// Description : Dual-issue control: issues, splits or stalls the ID bundle into EX.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_hazard_unit
    import issue_hazard_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    issue_hazard_unit_if.slave bus
);

    issue_state_t r_state;
    issue_state_t w_next_state;
    ex_slot_t     r_ex1, r_ex2;
    ex_slot_t     w_ex1_next, w_ex2_next;
    ex_slot_t     w_inst1, w_inst2;
    logic         w_lu1, w_lu2, w_dep, w_advance;

    assign w_inst1 = '{valid: 1'b1, regwrite: bus.id_regwrite1, memread: bus.id_memread1,
                       rs: bus.id_rs1, rt: bus.id_rt1, rd: bus.id_rd1};
    assign w_inst2 = '{valid: 1'b1, regwrite: bus.id_regwrite2, memread: bus.id_memread2,
                       rs: bus.id_rs2, rt: bus.id_rt2, rd: bus.id_rd2};

    lu_detect u_lu_inst1 (
        .i_rs          (bus.id_rs1),
        .i_rt          (bus.id_rt1),
        .i_ex1_valid   (r_ex1.valid),
        .i_ex1_memread (r_ex1.memread),
        .i_ex1_rd      (r_ex1.rd),
        .i_ex2_valid   (r_ex2.valid),
        .i_ex2_memread (r_ex2.memread),
        .i_ex2_rd      (r_ex2.rd),
        .o_hazard      (w_lu1)
    );

    lu_detect u_lu_inst2 (
        .i_rs          (bus.id_rs2),
        .i_rt          (bus.id_rt2),
        .i_ex1_valid   (r_ex1.valid),
        .i_ex1_memread (r_ex1.memread),
        .i_ex1_rd      (r_ex1.rd),
        .i_ex2_valid   (r_ex2.valid),
        .i_ex2_memread (r_ex2.memread),
        .i_ex2_rd      (r_ex2.rd),
        .o_hazard      (w_lu2)
    );

    // WAW inside a bundle is fine; only a slot-2 read of slot-1's result splits.
    assign w_dep = bus.id_regwrite1 && (bus.id_rd1 != REG_ZERO) &&
                   ((bus.id_rd1 == bus.id_rs2) || (bus.id_rd1 == bus.id_rt2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_PAIR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_PAIR: begin
                if (!bus.flush && bus.id_valid && !w_lu1 && (w_lu2 || w_dep)) begin
                    w_next_state = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (bus.flush || !w_lu2) begin
                    w_next_state = ST_PAIR;
                end
            end
            default: w_next_state = ST_PAIR;
        endcase
    end

    always_comb begin
        w_ex1_next = EX_BUBBLE;
        w_ex2_next = EX_BUBBLE;
        w_advance  = 1'b1;
        case (r_state)
            ST_PAIR: begin
                if (bus.flush || !bus.id_valid) begin
                    w_advance = 1'b1;
                end else if (w_lu1) begin
                    w_advance = 1'b0;
                end else if (w_lu2 || w_dep) begin
                    w_ex1_next = w_inst1;
                    w_advance  = 1'b0;
                end else begin
                    w_ex1_next = w_inst1;
                    w_ex2_next = w_inst2;
                end
            end
            ST_SECOND: begin
                // Slot 1 already left; the held inst2 keeps its slot-2 position.
                if (bus.flush) begin
                    w_advance = 1'b1;
                end else if (w_lu2) begin
                    w_advance = 1'b0;
                end else begin
                    w_ex2_next = w_inst2;
                end
            end
            default: w_advance = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex1 <= EX_BUBBLE;
            r_ex2 <= EX_BUBBLE;
        end else begin
            r_ex1 <= w_ex1_next;
            r_ex2 <= w_ex2_next;
        end
    end

    assign bus.pc_write     = w_advance && !rst;
    assign bus.if_id_write  = w_advance && !rst;

    assign bus.ex_valid1    = r_ex1.valid;
    assign bus.ex_regwrite1 = r_ex1.regwrite;
    assign bus.ex_memread1  = r_ex1.memread;
    assign bus.ex_rs1       = r_ex1.rs;
    assign bus.ex_rt1       = r_ex1.rt;
    assign bus.ex_rd1       = r_ex1.rd;
    assign bus.ex_valid2    = r_ex2.valid;
    assign bus.ex_regwrite2 = r_ex2.regwrite;
    assign bus.ex_memread2  = r_ex2.memread;
    assign bus.ex_rs2       = r_ex2.rs;
    assign bus.ex_rt2       = r_ex2.rt;
    assign bus.ex_rd2       = r_ex2.rd;

endmodule : issue_hazard_unit
`default_nettype wire

// File: tb/tb_issue_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_hazard_unit
// Description : Directed plus randomized checking of issue_hazard_unit against a rule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_hazard_unit;

    typedef struct packed {
        bit       v;
        bit       rw;
        bit       mr;
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] rd;
    } slot_t;

    localparam slot_t BUB = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    issue_hazard_unit_if bus ();

    issue_hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model of what EX holds and whether the bundle is half-issued.
    bit    m_second = 1'b0;
    slot_t m_ex0    = '0;
    slot_t m_ex1    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit lu(input slot_t e0, input slot_t e1, input slot_t x);
        slot_t ex [2];
        ex[0] = e0;
        ex[1] = e1;
        for (int k = 0; k < 2; k++) begin
            if (ex[k].v && ex[k].mr && ex[k].rd != 0 && (ex[k].rd == x.rs || ex[k].rd == x.rt))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void decide(input bit second, input slot_t e0, input slot_t e1,
                                   input slot_t i0, input slot_t i1, input bit valid, input bit flush,
                                   output bit nsec, output slot_t n0, output slot_t n1, output bit adv);
        bit dep;
        dep  = i0.rw && i0.rd != 0 && (i0.rd == i1.rs || i0.rd == i1.rt);
        nsec = 1'b0;
        n0   = BUB;
        n1   = BUB;
        adv  = 1'b1;
        if (flush) begin
            nsec = 1'b0;
        end else if (!second) begin
            if (!valid) begin
                adv = 1'b1;
            end else if (lu(e0, e1, i0)) begin
                adv = 1'b0;
            end else if (lu(e0, e1, i1) || dep) begin
                n0 = i0; adv = 1'b0; nsec = 1'b1;
            end else begin
                n0 = i0; n1 = i1;
            end
        end else begin
            if (lu(e0, e1, i1)) begin
                adv = 1'b0; nsec = 1'b1;
            end else begin
                n1 = i1;
            end
        end
    endfunction

    function automatic slot_t cur_ins(input int i);
        slot_t s;
        if (i == 0) s = '{1'b1, bus.id_regwrite1, bus.id_memread1, bus.id_rs1, bus.id_rt1, bus.id_rd1};
        else        s = '{1'b1, bus.id_regwrite2, bus.id_memread2, bus.id_rs2, bus.id_rt2, bus.id_rd2};
        return s;
    endfunction

    always @(posedge clk) begin
        bit    u_sec, u_adv;
        slot_t u0, u1;
        decide(m_second, m_ex0, m_ex1, cur_ins(0), cur_ins(1), bus.id_valid, bus.flush,
               u_sec, u0, u1, u_adv);
        if (rst) begin
            m_second <= 1'b0;
            m_ex0    <= BUB;
            m_ex1    <= BUB;
        end else begin
            m_second <= u_sec;
            m_ex0    <= u0;
            m_ex1    <= u1;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        bit    c_sec, c_adv;
        slot_t c0, c1;
        decide(m_second, m_ex0, m_ex1, cur_ins(0), cur_ins(1), bus.id_valid, bus.flush,
               c_sec, c0, c1, c_adv);
        chk("pc_write", 32'(bus.pc_write), 32'(c_adv && !rst));
        chk("if_id_write", 32'(bus.if_id_write), 32'(c_adv && !rst));
        chk("ex_slot1", 32'({bus.ex_valid1, bus.ex_regwrite1, bus.ex_memread1,
                             bus.ex_rs1, bus.ex_rt1, bus.ex_rd1}), 32'(m_ex0));
        chk("ex_slot2", 32'({bus.ex_valid2, bus.ex_regwrite2, bus.ex_memread2,
                             bus.ex_rs2, bus.ex_rt2, bus.ex_rd2}), 32'(m_ex1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v,
                          input int rs1, input int rt1, input int rd1, input bit rw1, input bit mr1,
                          input int rs2, input int rt2, input int rd2, input bit rw2, input bit mr2);
        bus.id_valid     = v;
        bus.id_rs1       = 5'(rs1);
        bus.id_rt1       = 5'(rt1);
        bus.id_rd1       = 5'(rd1);
        bus.id_regwrite1 = rw1;
        bus.id_memread1  = mr1;
        bus.id_rs2       = 5'(rs2);
        bus.id_rt2       = 5'(rt2);
        bus.id_rd2       = 5'(rd2);
        bus.id_regwrite2 = rw2;
        bus.id_memread2  = mr2;
    endtask

    initial begin
        bus.flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        #1 chk("pc_write_in_reset", 32'(bus.pc_write), 32'd0);
        tick();
        chk("reset_ex_valid1", 32'(bus.ex_valid1), 32'd0);
        rst = 1'b0;

        // Independent pair
        set_id(1, 1, 2, 3, 1, 0, 4, 5, 6, 1, 0);
        #1 chk("pair_pc_write", 32'(bus.pc_write), 32'd1);
        tick();
        chk("pair_valid", 32'({bus.ex_valid1, bus.ex_valid2}), 32'b11);
        chk("pair_rd1", 32'(bus.ex_rd1), 32'd3);
        chk("pair_rd2", 32'(bus.ex_rd2), 32'd6);

        // Dependency split
        set_id(1, 1, 2, 3, 1, 0, 3, 7, 9, 1, 0);
        #1 chk("dep_pc_write", 32'(bus.pc_write), 32'd0);
        tick();
        chk("dep_c1_valid", 32'({bus.ex_valid1, bus.ex_valid2}), 32'b10);
        #1 chk("dep_c1_pc_write", 32'(bus.pc_write), 32'd1);
        tick();
        chk("dep_c2_valid", 32'({bus.ex_valid1, bus.ex_valid2}), 32'b01);
        chk("dep_c2_rs2", 32'(bus.ex_rs2), 32'd3);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("dep_back_to_pair", 32'(bus.pc_write), 32'd1);

        // Load-use on slot 1
        set_id(1, 1, 0, 8, 1, 1, 4, 5, 10, 1, 0);
        tick();
        set_id(1, 8, 2, 11, 1, 0, 4, 5, 12, 1, 0);
        #1 chk("lu1_stall", 32'({bus.pc_write, bus.if_id_write}), 32'b00);
        tick();
        chk("lu1_bubble", 32'({bus.ex_valid1, bus.ex_valid2}), 32'b00);
        #1 chk("lu1_resume", 32'(bus.pc_write), 32'd1);
        tick();
        chk("lu1_issue_rd1", 32'({bus.ex_valid1, bus.ex_rd1}), 32'({1'b1, 5'd11}));

        // Load-use on slot 2 only
        set_id(1, 1, 0, 8, 1, 1, 4, 5, 10, 1, 0);
        tick();
        set_id(1, 1, 2, 13, 1, 0, 4, 8, 14, 1, 0);
        #1 chk("lu2_pc_write", 32'(bus.pc_write), 32'd0);
        tick();
        chk("lu2_c1", 32'({bus.ex_valid1, bus.ex_valid2, bus.ex_rd1}), 32'({2'b10, 5'd13}));
        tick();
        chk("lu2_c2", 32'({bus.ex_valid1, bus.ex_valid2, bus.ex_rd2}), 32'({2'b01, 5'd14}));

        // $0 never splits; flush out of SECOND
        set_id(1, 1, 2, 0, 1, 0, 0, 3, 15, 1, 0);
        #1 chk("zero_no_split", 32'(bus.pc_write), 32'd1);
        tick();
        set_id(1, 1, 2, 3, 1, 0, 3, 4, 16, 1, 0);
        tick();
        bus.flush = 1'b1;
        #1 chk("flush_pc_write", 32'(bus.pc_write), 32'd1);
        tick();
        bus.flush = 1'b0;
        chk("flush_bubble", 32'({bus.ex_valid1, bus.ex_valid2}), 32'b00);
        set_id(1, 1, 2, 17, 1, 0, 4, 5, 18, 1, 0);
        tick();
        chk("flush_then_pair", 32'({bus.ex_valid1, bus.ex_valid2}), 32'b11);

        // Reset while in SECOND
        set_id(1, 1, 2, 3, 1, 0, 3, 4, 19, 1, 0);
        tick();
        rst = 1'b1;
        #1 chk("rst_pc_write", 32'(bus.pc_write), 32'd0);
        tick();
        chk("rst_ex1", 32'({bus.ex_valid1, bus.ex_rd1}), 32'd0);
        rst = 1'b0;
        set_id(1, 1, 2, 20, 1, 0, 4, 5, 21, 1, 0);
        tick();
        chk("rst_then_pair", 32'({bus.ex_valid1, bus.ex_valid2}), 32'b11);

        // Randomized traffic on a small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            set_id($urandom_range(0, 99) < 85,
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom), 1'($urandom),
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom), 1'($urandom));
            tick();
        end
        rst = 1'b0;
        bus.flush = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_issue_hazard_unit
`default_nettype wire
